// File: rtl/mux_nx1_if.sv
// Signal bundle for the registered 4-to-1 word multiplexer: four data words,
// the select code and the registered result.
interface mux_nx1_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] D0;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic [WIDTH-1:0] D3;
    logic [1:0]       sel;
    logic [WIDTH-1:0] Y;

    modport master (
        output D0, D1, D2, D3, sel,
        input  Y
    );

    modport slave (
        input  D0, D1, D2, D3, sel,
        output Y
    );
endinterface

// File: rtl/mux_nx1.sv
// Registered 4-to-1 word multiplexer: the word picked by sel appears on Y one
// clock later; asynchronous active-high reset clears Y.
module mux_nx1 #(
    parameter int WIDTH = 3
) (
    input logic       clk,
    input logic       rst,
    mux_nx1_if.slave  bus
);
    logic [WIDTH-1:0] next_y;

    // An unknown select propagates as X rather than quietly picking D0.
    always_comb begin
        next_y = 'x;
        case (bus.sel)
            2'b00:   next_y = bus.D0;
            2'b01:   next_y = bus.D1;
            2'b10:   next_y = bus.D2;
            2'b11:   next_y = bus.D3;
            default: next_y = 'x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.Y <= '0;
        end else begin
            bus.Y <= next_y;
        end
    end
endmodule

// File: tb/tb_mux_nx1.sv
// Scoreboard bench for mux_nx1: stimulus queues hand-computed expectations,
// a monitor pops them after each rising edge or on an explicit mid-cycle probe.
module tb_mux_nx1;
    typedef struct {
        string      name;
        logic [2:0] exp3;
        logic [7:0] exp8;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   active = 1'b0;
    exp_t q[$];
    event probe;

    always #5 clk = ~clk;

    mux_nx1_if #(.WIDTH(3)) bus3 ();
    mux_nx1_if #(.WIDTH(8)) bus8 ();

    mux_nx1 #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    mux_nx1 #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    // Monitor: one pop per rising edge once stimulus is running, plus one per probe.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or probe);
            #1;
            if (q.size() == 0) begin
                if (active) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL underflow: no expectation queued at %0t", $time);
                end
            end else begin
                e = q.pop_front();
                n_cmp++;
                if (bus3.Y !== e.exp3) begin
                    n_fail++;
                    $display("FAIL %s (w3): got %b, want %b at %0t", e.name, bus3.Y, e.exp3, $time);
                end
                n_cmp++;
                if (bus8.Y !== e.exp8) begin
                    n_fail++;
                    $display("FAIL %s (w8): got %h, want %h at %0t", e.name, bus8.Y, e.exp8, $time);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] d0, input logic [2:0] d1, input logic [2:0] d2,
                         input logic [2:0] d3, input logic [1:0] s, input logic [1:0] s8,
                         input logic r);
        @(negedge clk);
        bus3.D0 = d0; bus3.D1 = d1; bus3.D2 = d2; bus3.D3 = d3; bus3.sel = s;
        bus8.sel = s8;
        rst = r;
    endtask

    task automatic expect_edge(input string name, input logic [2:0] e3, input logic [7:0] e8);
        exp_t e;
        e.name = name; e.exp3 = e3; e.exp8 = e8;
        q.push_back(e);
        active = 1'b1;
    endtask

    task automatic mid(input string name, input logic [2:0] e3, input logic [7:0] e8);
        exp_t e;
        e.name = name; e.exp3 = e3; e.exp8 = e8;
        q.push_back(e);
        -> probe;
        #2;
    endtask

    initial begin
        bus3.D0 = 3'b001; bus3.D1 = 3'b010; bus3.D2 = 3'b101; bus3.D3 = 3'b110;
        bus3.sel = 2'b00;
        bus8.D0 = 8'h00; bus8.D1 = 8'h5A; bus8.D2 = 8'hA5; bus8.D3 = 8'hFF;
        bus8.sel = 2'b00;
        rst = 1'b1;
        #2;
        mid("reset_t0", 3'b000, 8'h00);

        // Held in reset with clk running
        repeat (3) begin
            drive(3'b001, 3'b010, 3'b101, 3'b110, 2'b00, 2'b00, 1'b1);
            expect_edge("reset_hold", 3'b000, 8'h00);
        end
        drive(3'b001, 3'b010, 3'b101, 3'b110, 2'b00, 2'b00, 1'b0);
        mid("release_no_edge", 3'b000, 8'h00);
        expect_edge("reset_release", 3'b001, 8'h00);

        // Select sweep
        drive(3'b001, 3'b010, 3'b101, 3'b110, 2'b01, 2'b00, 1'b0);
        expect_edge("sweep_01", 3'b010, 8'h00);
        drive(3'b001, 3'b010, 3'b101, 3'b110, 2'b10, 2'b00, 1'b0);
        expect_edge("sweep_10", 3'b101, 8'h00);
        drive(3'b001, 3'b010, 3'b101, 3'b110, 2'b11, 2'b00, 1'b0);
        expect_edge("sweep_11", 3'b110, 8'h00);
        drive(3'b001, 3'b010, 3'b101, 3'b110, 2'b00, 2'b00, 1'b0);
        expect_edge("sweep_00", 3'b001, 8'h00);

        // Latency: sel 00 -> 11 mid-cycle must not reach Y before the edge
        drive(3'b001, 3'b010, 3'b101, 3'b110, 2'b11, 2'b00, 1'b0);
        mid("latency_hold", 3'b001, 8'h00);
        expect_edge("latency_load", 3'b110, 8'h00);

        // Asynchronous reset between edges
        drive(3'b001, 3'b010, 3'b101, 3'b110, 2'b10, 2'b00, 1'b0);
        expect_edge("pre_reset_sel10", 3'b101, 8'h00);
        drive(3'b001, 3'b010, 3'b101, 3'b110, 2'b10, 2'b00, 1'b0);
        mid("pre_pulse", 3'b101, 8'h00);
        rst = 1'b1;
        mid("async_clear", 3'b000, 8'h00);
        rst = 1'b0;
        expect_edge("post_pulse_reload", 3'b101, 8'h00);

        // Data change at fixed sel = 01
        drive(3'b001, 3'b010, 3'b101, 3'b110, 2'b01, 2'b00, 1'b0);
        expect_edge("sel01_d1_010", 3'b010, 8'h00);
        drive(3'b001, 3'b111, 3'b101, 3'b110, 2'b01, 2'b00, 1'b0);
        expect_edge("sel01_d1_111", 3'b111, 8'h00);
        drive(3'b000, 3'b111, 3'b000, 3'b000, 2'b01, 2'b00, 1'b0);
        expect_edge("other_data_change", 3'b111, 8'h00);

        // Simultaneous sel + data change picks the new word
        drive(3'b011, 3'b111, 3'b000, 3'b100, 2'b11, 2'b00, 1'b0);
        expect_edge("sel_and_data", 3'b100, 8'h00);

        // WIDTH=8 sweep
        drive(3'b011, 3'b111, 3'b000, 3'b100, 2'b11, 2'b01, 1'b0);
        expect_edge("w8_sel01", 3'b100, 8'h5A);
        drive(3'b011, 3'b111, 3'b000, 3'b100, 2'b11, 2'b10, 1'b0);
        expect_edge("w8_sel10", 3'b100, 8'hA5);
        drive(3'b011, 3'b111, 3'b000, 3'b100, 2'b11, 2'b11, 1'b0);
        expect_edge("w8_sel11", 3'b100, 8'hFF);
        drive(3'b011, 3'b111, 3'b000, 3'b100, 2'b00, 2'b00, 1'b0);
        expect_edge("w8_sel00", 3'b011, 8'h00);

        begin
            int unsigned waited = 0;
            while (q.size() != 0 && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (q.size() != 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL drain: %0d expectations left, want 0", q.size());
            end
        end
        active = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mux_nx1.md
# mux_nx1

Parameterized 4-to-1 multiplexer with a registered output. Selects one of four WIDTH-bit data words by a 2-bit select and presents it on Y one clock later. Used as a generic datapath steering element wherever a word-wide, glitch-free, reset-defined selection is needed.

## Interface

Parameters:
- WIDTH, default 3: bit width of every data input and of Y; legal range is 1 or greater.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  system clock; all state updates occur on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears Y.
- D0  input  WIDTH  data word selected when sel = 2'b00.
- D1  input  WIDTH  data word selected when sel = 2'b01.
- D2  input  WIDTH  data word selected when sel = 2'b10.
- D3  input  WIDTH  data word selected when sel = 2'b11.
- sel  input  2  select code.
- Y  output  WIDTH  registered selected word.

## Operation

- Combinational select path:
  - next_Y = D0 when sel = 00.
  - next_Y = D1 when sel = 01.
  - next_Y = D2 when sel = 10.
  - next_Y = D3 when sel = 11.
- If sel contains X or Z in simulation, next_Y is all-X. No silent default to D0.
- On every rising clk edge with rst low, Y <= next_Y. There is no enable; Y reloads every cycle.
- While rst is high, Y = {WIDTH{1'b0}} regardless of clk, sel or data inputs.
- Word-wide copy only: no bit reordering, no sign or zero extension, no arithmetic.
- Y is driven only by the output register. There is no combinational path from D*/sel to Y.

## Timing

- Latency: 1 cycle. The value selected by sel and D* sampled at rising edge k appears on Y immediately after edge k and holds until edge k+1.
- Reset assertion clears Y asynchronously, within the same delta and with no clock needed.
- Reset deassertion is sampled synchronously. The first load happens at the first rising edge on which rst is low.
- If rst deasserts coincident with a rising edge, that edge does not load. Y stays 0 until the next edge.
- Reset mid-operation: Y goes to 0 immediately. The prior selection is not retained.
- sel and data changes between edges have no effect on Y until the next rising edge. There are no output glitches.
- If sel and the D* inputs change together before an edge, the new sel selects the new data word.

## Test plan

- Reset: D0=001, D1=010, D2=101, D3=110, sel=00, rst=1 with clk toggling. Required: Y=000 throughout. Release rst; after the next rising edge Y=001.
- Sweep: hold the data from the reset test and step sel through 00, 01, 10, 11, one change per 10 ns period. Required: Y=001, 010, 101, 110 respectively, each appearing one edge after the sel change.
- Latency check: change sel 00 to 11 mid-cycle. Required: Y stays 001 until the next rising edge, then becomes 110.
- Asynchronous reset mid-run: with sel=10 and Y=101, pulse rst between edges. Required: Y=000 immediately, before any clock edge. After release, the next edge loads 101 again.
- Data change at fixed sel: hold sel=01 and change D1 from 010 to 111. Required: Y=111 after the next edge. Changing D0, D2 or D3 leaves Y at 111.
- Width parameter: instantiate with WIDTH=8, D0=0x00, D1=0x5A, D2=0xA5, D3=0xFF and sweep sel. Required: Y=0x00, 0x5A, 0xA5, 0xFF.
